// File: rtl/rgb_hue_sequencer.sv
// ============================================================================
// Module   : rgb_hue_sequencer
// Purpose  : Six-sector hue ramp for the RGB LED, with per-channel PWM drive.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_hue_sequencer #(
    parameter int PWM_WIDTH = 8,
    parameter int STEP_DIV  = 7812
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [PWM_WIDTH-1:0] duty_r,
    output logic [PWM_WIDTH-1:0] duty_g,
    output logic [PWM_WIDTH-1:0] duty_b,
    output logic [2:0]           sector,
    output logic                 pwm_r,
    output logic                 pwm_g,
    output logic                 pwm_b,
    output logic                 cycle_done
);

    localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_WIDTH-1:0] c_max      = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] c_zero     = '0;
    localparam logic [PRE_W-1:0]     c_pre_last = PRE_W'(STEP_DIV - 1);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    logic [PRE_W-1:0]     r_prescaler;
    logic [PWM_WIDTH-1:0] r_ramp;
    logic [2:0]           r_sector;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic                 w_step_tick;

    assign w_step_tick = enable && (r_prescaler == c_pre_last);
    assign sector      = r_sector;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
            r_ramp      <= '0;
            r_sector    <= S0;
            r_pwm_cnt   <= '0;
            pwm_r       <= 1'b0;
            pwm_g       <= 1'b0;
            pwm_b       <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            if (enable) begin
                r_prescaler <= w_step_tick ? '0 : r_prescaler + PRE_W'(1);
            end

            if (w_step_tick) begin
                // Illegal sector codes recover to the start of the cycle.
                if (r_sector > S5) begin
                    r_sector <= S0;
                    r_ramp   <= '0;
                end else if (r_ramp != c_max) begin
                    r_ramp <= r_ramp + PWM_WIDTH'(1);
                end else begin
                    r_ramp   <= '0;
                    r_sector <= (r_sector == S5) ? S0 : r_sector + 3'd1;
                end
            end

            r_pwm_cnt  <= r_pwm_cnt + PWM_WIDTH'(1);
            pwm_r      <= (r_pwm_cnt < duty_r);
            pwm_g      <= (r_pwm_cnt < duty_g);
            pwm_b      <= (r_pwm_cnt < duty_b);
            cycle_done <= w_step_tick && (r_ramp == c_max) && (r_sector == S5);
        end
    end

    always_comb begin
        duty_r = c_zero;
        duty_g = c_zero;
        duty_b = c_zero;
        case (r_sector)
            S0: begin duty_r = c_max;          duty_g = r_ramp;         duty_b = c_zero;         end
            S1: begin duty_r = c_max - r_ramp; duty_g = c_max;          duty_b = c_zero;         end
            S2: begin duty_r = c_zero;         duty_g = c_max;          duty_b = r_ramp;         end
            S3: begin duty_r = c_zero;         duty_g = c_max - r_ramp; duty_b = c_max;          end
            S4: begin duty_r = r_ramp;         duty_g = c_zero;         duty_b = c_max;          end
            S5: begin duty_r = c_max;          duty_g = c_zero;         duty_b = c_max - r_ramp; end
            default: begin duty_r = c_zero;    duty_g = c_zero;         duty_b = c_zero;         end
        endcase
    end

endmodule

`default_nettype wire
